// File: rtl/ddr3_wb_multiport_arbiter.sv
// N-port pipelined Wishbone arbiter in front of ddr3_controller; acks are routed back by a port tag in aux.
// Define DDR3_ARB_FIXED_PRIORITY_EN for fixed priority (port 0 highest); default is round-robin.
module ddr3_wb_multiport_arbiter #(
  parameter int NUM_PORTS       = 4,
  parameter int WB_ADDR_BITS    = 24,
  parameter int WB_DATA_BITS    = 512,
  parameter int AUX_WIDTH       = 16,
  parameter int MAX_OUTSTANDING = 16,
  parameter int MAX_BURST       = 8,
  localparam int PORT_BITS      = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1,
  localparam int SEL_BITS       = WB_DATA_BITS / 8
) (
  input  logic                              i_controller_clk,
  input  logic                              i_rst,
  input  logic [NUM_PORTS-1:0]              i_wb_cyc,
  input  logic [NUM_PORTS-1:0]              i_wb_stb,
  input  logic [NUM_PORTS-1:0]              i_wb_we,
  input  logic [NUM_PORTS*WB_ADDR_BITS-1:0] i_wb_addr,
  input  logic [NUM_PORTS*WB_DATA_BITS-1:0] i_wb_data,
  input  logic [NUM_PORTS*SEL_BITS-1:0]     i_wb_sel,
  input  logic [NUM_PORTS*AUX_WIDTH-1:0]    i_aux,
  output logic [NUM_PORTS-1:0]              o_wb_stall,
  output logic [NUM_PORTS-1:0]              o_wb_ack,
  output logic [WB_DATA_BITS-1:0]           o_wb_data,
  output logic [AUX_WIDTH-1:0]              o_aux,
  output logic                              o_ctl_wb_cyc,
  output logic                              o_ctl_wb_stb,
  output logic                              o_ctl_wb_we,
  output logic [WB_ADDR_BITS-1:0]           o_ctl_wb_addr,
  output logic [WB_DATA_BITS-1:0]           o_ctl_wb_data,
  output logic [SEL_BITS-1:0]               o_ctl_wb_sel,
  output logic [AUX_WIDTH+PORT_BITS-1:0]    o_ctl_aux,
  input  logic                              i_ctl_wb_stall,
  input  logic                              i_ctl_wb_ack,
  input  logic [WB_DATA_BITS-1:0]           i_ctl_wb_data,
  input  logic [AUX_WIDTH+PORT_BITS-1:0]    i_ctl_aux
);

  localparam int OUT_BITS   = $clog2(MAX_OUTSTANDING) + 1;
  localparam int BURST_BITS = $clog2(MAX_BURST + 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_GRANTED = 2'd1;
  localparam logic [1:0] S_DRAIN   = 2'd2;

  logic [1:0]            state, state_nxt;
  logic [PORT_BITS-1:0]  grant_idx, pick_idx;
  logic                  pick_valid;
  logic [OUT_BITS-1:0]   outstanding;
  logic [BURST_BITS-1:0] burst_cnt;
  logic [NUM_PORTS-1:0]  req;

  logic [WB_ADDR_BITS-1:0] addr_arr [NUM_PORTS];
  logic [WB_DATA_BITS-1:0] data_arr [NUM_PORTS];
  logic [SEL_BITS-1:0]     sel_arr  [NUM_PORTS];
  logic [AUX_WIDTH-1:0]    aux_arr  [NUM_PORTS];

  logic grant_valid, g_cyc, g_stb, aborting, out_full, burst_full, hold, accept;
  logic [PORT_BITS-1:0] ack_tag;

  always_comb begin
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      addr_arr[p] = i_wb_addr[p*WB_ADDR_BITS +: WB_ADDR_BITS];
      data_arr[p] = i_wb_data[p*WB_DATA_BITS +: WB_DATA_BITS];
      sel_arr[p]  = i_wb_sel[p*SEL_BITS +: SEL_BITS];
      aux_arr[p]  = i_aux[p*AUX_WIDTH +: AUX_WIDTH];
    end
  end

  assign req = i_wb_cyc & i_wb_stb;

`ifdef DDR3_ARB_FIXED_PRIORITY_EN
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int unsigned i = NUM_PORTS; i > 0; i--) begin
      if (req[i-1]) begin
        pick_valid = 1'b1;
        pick_idx   = PORT_BITS'(i - 1);
      end
    end
  end
`else
  logic [PORT_BITS-1:0] rr_ptr, cand;

  // Scan farthest-to-nearest so the port closest after rr_ptr wins.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int unsigned i = NUM_PORTS; i > 0; i--) begin
      cand = PORT_BITS'((32'(rr_ptr) + i) % NUM_PORTS);
      if (req[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end
`endif

  assign grant_valid = (state != S_IDLE);
  assign g_cyc       = i_wb_cyc[grant_idx];
  assign g_stb       = i_wb_stb[grant_idx];
  assign aborting    = grant_valid & ~g_cyc;
  assign out_full    = (outstanding == OUT_BITS'(MAX_OUTSTANDING));
  assign burst_full  = (burst_cnt == BURST_BITS'(MAX_BURST));
  assign hold        = i_ctl_wb_stall | out_full | burst_full;
  assign accept      = o_ctl_wb_stb & ~i_ctl_wb_stall;
  assign ack_tag     = i_ctl_aux[AUX_WIDTH +: PORT_BITS];

  assign o_ctl_wb_cyc  = grant_valid & g_cyc;
  assign o_ctl_wb_stb  = (state == S_GRANTED) & g_cyc & g_stb & ~hold;
  assign o_ctl_wb_we   = i_wb_we[grant_idx];
  assign o_ctl_wb_addr = addr_arr[grant_idx];
  assign o_ctl_wb_data = data_arr[grant_idx];
  assign o_ctl_wb_sel  = sel_arr[grant_idx];
  assign o_ctl_aux     = {grant_idx, aux_arr[grant_idx]};

  assign o_wb_data = i_ctl_wb_data;
  assign o_aux     = i_ctl_aux[AUX_WIDTH-1:0];

  always_comb begin
    o_wb_stall = '1;
    if (state == S_GRANTED) o_wb_stall[grant_idx] = hold;
  end

  // Acks for the port being aborted this cycle belong to the cancelled cycle.
  always_comb begin
    o_wb_ack = '0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      o_wb_ack[p] = i_ctl_wb_ack & ~i_rst & (ack_tag == PORT_BITS'(p))
                    & ~(aborting & (grant_idx == PORT_BITS'(p)));
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (pick_valid) state_nxt = S_GRANTED;
      S_GRANTED: begin
        if (!g_cyc) state_nxt = S_IDLE;
        else if (!g_stb || burst_full ||
                 (accept && burst_cnt == BURST_BITS'(MAX_BURST - 1))) state_nxt = S_DRAIN;
      end
      S_DRAIN:   if (!g_cyc || outstanding == '0) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_controller_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= S_IDLE;
      grant_idx   <= '0;
      outstanding <= '0;
      burst_cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && pick_valid) begin
        grant_idx <= pick_idx;
        burst_cnt <= '0;
      end else if (accept) begin
        burst_cnt <= burst_cnt + BURST_BITS'(1);
      end
      if (aborting)
        outstanding <= '0;
      else if (accept && !i_ctl_wb_ack)
        outstanding <= outstanding + OUT_BITS'(1);
      else if (!accept && i_ctl_wb_ack && outstanding != '0)
        outstanding <= outstanding - OUT_BITS'(1);
    end
  end

`ifndef DDR3_ARB_FIXED_PRIORITY_EN
  always_ff @(posedge i_controller_clk or posedge i_rst) begin
    if (i_rst)                          rr_ptr <= PORT_BITS'(NUM_PORTS - 1);
    else if (state == S_IDLE && pick_valid) rr_ptr <= pick_idx;
  end
`endif

endmodule

// File: tb/tb_ddr3_wb_multiport_arbiter.sv
// Self-checking bench for ddr3_wb_multiport_arbiter: directed corner cases, then random traffic
// against a transaction-level model of grant order, tag routing and in-order acks.
module tb_ddr3_wb_multiport_arbiter;

  localparam int NP = 4;
  localparam int AW = 24;
  localparam int DW = 64;
  localparam int XW = 16;
  localparam int MO = 4;
  localparam int MB = 6;
  localparam int PB = 2;
  localparam int SW = DW / 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [NP-1:0]     wb_cyc, wb_stb, wb_we;
  logic [NP*AW-1:0]  wb_addr;
  logic [NP*DW-1:0]  wb_data;
  logic [NP*SW-1:0]  wb_sel;
  logic [NP*XW-1:0]  wb_aux;
  logic [NP-1:0]     o_wb_stall, o_wb_ack;
  logic [DW-1:0]     o_wb_data;
  logic [XW-1:0]     o_aux;
  logic              o_ctl_wb_cyc, o_ctl_wb_stb, o_ctl_wb_we;
  logic [AW-1:0]     o_ctl_wb_addr;
  logic [DW-1:0]     o_ctl_wb_data;
  logic [SW-1:0]     o_ctl_wb_sel;
  logic [XW+PB-1:0]  o_ctl_aux;
  logic              ctl_stall, ctl_ack;
  logic [DW-1:0]     ctl_data;
  logic [XW+PB-1:0]  ctl_aux;

  always #5 clk = ~clk;

  ddr3_wb_multiport_arbiter #(
    .NUM_PORTS(NP), .WB_ADDR_BITS(AW), .WB_DATA_BITS(DW), .AUX_WIDTH(XW),
    .MAX_OUTSTANDING(MO), .MAX_BURST(MB)
  ) dut (
    .i_controller_clk(clk), .i_rst(rst),
    .i_wb_cyc(wb_cyc), .i_wb_stb(wb_stb), .i_wb_we(wb_we), .i_wb_addr(wb_addr),
    .i_wb_data(wb_data), .i_wb_sel(wb_sel), .i_aux(wb_aux),
    .o_wb_stall(o_wb_stall), .o_wb_ack(o_wb_ack), .o_wb_data(o_wb_data), .o_aux(o_aux),
    .o_ctl_wb_cyc(o_ctl_wb_cyc), .o_ctl_wb_stb(o_ctl_wb_stb), .o_ctl_wb_we(o_ctl_wb_we),
    .o_ctl_wb_addr(o_ctl_wb_addr), .o_ctl_wb_data(o_ctl_wb_data), .o_ctl_wb_sel(o_ctl_wb_sel),
    .o_ctl_aux(o_ctl_aux),
    .i_ctl_wb_stall(ctl_stall), .i_ctl_wb_ack(ctl_ack), .i_ctl_wb_data(ctl_data), .i_ctl_aux(ctl_aux)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_port(input int p, input logic c, input logic s, input logic w,
                          input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [SW-1:0] sl, input logic [XW-1:0] x);
    wb_cyc[p] = c;
    wb_stb[p] = s;
    wb_we[p]  = w;
    wb_addr[p*AW +: AW] = a;
    wb_data[p*DW +: DW] = d;
    wb_sel[p*SW +: SW]  = sl;
    wb_aux[p*XW +: XW]  = x;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Random-phase model state
  typedef struct { int port; logic [XW-1:0] aux; logic [DW-1:0] data; int due; } rsp_t;
  rsp_t rq[$];
  int n_items [NP];
  int issued  [NP];
  int acked   [NP];
  logic [AW-1:0] it_addr [NP][12];
  logic [DW-1:0] it_data [NP][12];
  logic [SW-1:0] it_sel  [NP][12];
  logic [XW-1:0] it_aux  [NP][12];
  logic          it_we   [NP][12];

  function automatic int pick_next(input int last);
`ifdef DDR3_ARB_FIXED_PRIORITY_EN
    for (int i = 0; i < NP; i++) if (issued[i] < n_items[i]) return i;
`else
    for (int i = 1; i <= NP; i++) begin
      int c;
      c = (last + i) % NP;
      if (issued[c] < n_items[c]) return c;
    end
`endif
    return -1;
  endfunction

  initial begin
    logic [NP-1:0] exp_vec;
    int turn_port, turn_cnt, model_out, cyc_no, e, last_due;
    bit all_done;

    rst = 1'b1;
    wb_cyc = '0; wb_stb = '0; wb_we = '0; wb_addr = '0; wb_data = '0; wb_sel = '0; wb_aux = '0;
    ctl_stall = 1'b0; ctl_ack = 1'b0; ctl_data = '0; ctl_aux = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall", o_wb_stall, 4'hf);
    chk("rst_cyc", o_ctl_wb_cyc, 0);
    chk("rst_stb", o_ctl_wb_stb, 0);
    chk("rst_ack", o_wb_ack, 0);
    rst = 1'b0;
    tick();

    // Tag routing
    ctl_ack = 1'b1; ctl_aux = {2'd3, 16'hBEEF}; ctl_data = 64'h0123_4567_89ab_cdef;
    #1;
    chk("tag_ack", o_wb_ack, 4'b1000);
    chk("tag_aux", o_aux, 16'hbeef);
    chk("tag_data", o_wb_data, 64'h0123_4567_89ab_cdef);
    ctl_aux = {2'd1, 16'h1234};
    #1;
    chk("tag_ack1", o_wb_ack, 4'b0010);
    tick();
    ctl_ack = 1'b0;

    // Outstanding limit on port 0
    set_port(0, 1, 1, 1, 24'h000100, 64'hdead_beef_0000_0001, 8'hff, 16'h0a0a);
    #1;
    chk("idle_stall", o_wb_stall, 4'hf);
    tick();
    chk("lim_addr", o_ctl_wb_addr, 24'h000100);
    chk("lim_tag", o_ctl_aux, {2'd0, 16'h0a0a});
    for (int k = 0; k < MO; k++) begin
      chk("lim_stall_lo", o_wb_stall[0], 0);
      chk("lim_stb", o_ctl_wb_stb, 1);
      tick();
    end
    chk("lim_full_stall", o_wb_stall[0], 1);
    chk("lim_full_stb", o_ctl_wb_stb, 0);
    ctl_ack = 1'b1; ctl_aux = {2'd0, 16'h0a0a};
    #1;
    chk("lim_ack0", o_wb_ack, 4'b0001);
    chk("lim_stall_ackcyc", o_wb_stall[0], 1);
    tick();
    chk("lim_reopen", o_wb_stall[0], 0);
    tick();
    ctl_ack = 1'b0;
    #1;
    chk("lim_same", o_wb_stall[0], 0);
    tick();
    chk("lim_refull", o_wb_stall[0], 1);

    // Asynchronous reset mid-transfer
    ctl_ack = 1'b1;
    rst = 1'b1;
    #1;
    chk("mrst_stall", o_wb_stall, 4'hf);
    chk("mrst_cyc", o_ctl_wb_cyc, 0);
    chk("mrst_ack", o_wb_ack, 0);
    tick();
    rst = 1'b0; ctl_ack = 1'b0;
    tick();
    chk("post_rst_stall", o_wb_stall[0], 0);

    // Abort: port 1 drops cyc with two outstanding
    set_port(0, 0, 0, 0, '0, '0, '0, '0);
    set_port(1, 1, 1, 0, 24'h000200, 64'h1111, 8'h0f, 16'h1111);
    set_port(2, 1, 1, 0, 24'h000300, 64'h2222, 8'hf0, 16'h2222);
    #1;
    chk("abort0_cyc", o_ctl_wb_cyc, 0);
    tick();
    chk("ab_idle0", o_wb_stall, 4'hf);
    tick();
    chk("ab_tag1", o_ctl_aux[XW +: PB], 1);
    chk("ab_stb1", o_ctl_wb_stb, 1);
    tick();
    chk("ab_stb2", o_ctl_wb_stb, 1);
    tick();
    set_port(1, 0, 0, 0, '0, '0, '0, '0);
    ctl_ack = 1'b1; ctl_aux = {2'd1, 16'h1111};
    #1;
    chk("ab_cyc", o_ctl_wb_cyc, 0);
    chk("ab_ack_sup", o_wb_ack, 0);
    tick();
    ctl_ack = 1'b0;
    #1;
    chk("ab_idle", o_wb_stall, 4'hf);
    tick();
    chk("ab_next", o_ctl_aux[XW +: PB], 2);
    chk("ab_next_stall", o_wb_stall, 4'b1011);
    set_port(2, 0, 0, 0, '0, '0, '0, '0);
    tick();

    // Random traffic against the transaction-level model
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int p = 0; p < NP; p++) begin
      n_items[p] = $urandom_range(0, 11);
      issued[p] = 0;
      acked[p] = 0;
      for (int k = 0; k < 12; k++) begin
        it_addr[p][k] = AW'($urandom);
        it_data[p][k] = {$urandom, $urandom};
        it_sel[p][k]  = SW'($urandom);
        it_aux[p][k]  = XW'($urandom);
        it_we[p][k]   = 1'($urandom);
      end
    end
    turn_port = NP - 1;
    turn_cnt = MB;
    model_out = 0;
    cyc_no = 0;
    last_due = 0;
    all_done = 1'b0;
    while (!all_done && cyc_no < 4000) begin
      tick();
      for (int p = 0; p < NP; p++) begin
        if (issued[p] < n_items[p])
          set_port(p, 1, 1, it_we[p][issued[p]], it_addr[p][issued[p]], it_data[p][issued[p]],
                   it_sel[p][issued[p]], it_aux[p][issued[p]]);
        else if (acked[p] < n_items[p])
          set_port(p, 1, 0, 0, '0, '0, '0, '0);
        else
          set_port(p, 0, 0, 0, '0, '0, '0, '0);
      end
      ctl_stall = ($urandom_range(0, 3) == 0);
      if (rq.size() > 0 && rq[0].due <= cyc_no) begin
        ctl_ack = 1'b1;
        ctl_aux = {PB'(rq[0].port), rq[0].aux};
        ctl_data = rq[0].data;
      end else begin
        ctl_ack = 1'b0;
        ctl_aux = '0;
        ctl_data = {$urandom, $urandom};
      end
      #1;
      if (o_ctl_wb_stb && !ctl_stall) begin
        if (turn_cnt >= MB || issued[turn_port] >= n_items[turn_port]) begin
          e = pick_next(turn_port);
          chk("rnd_switch_out", model_out, 0);
          turn_port = (e < 0) ? turn_port : e;
          turn_cnt = 0;
        end else begin
          e = turn_port;
        end
        if (e < 0) begin
          chk("rnd_unexpected_accept", 0, 1);
        end else begin
          exp_vec = '1;
          exp_vec[e] = 1'b0;
          chk("rnd_stall", o_wb_stall, exp_vec);
          chk("rnd_port", o_ctl_aux[XW +: PB], e);
          chk("rnd_aux", o_ctl_aux[XW-1:0], it_aux[e][issued[e]]);
          chk("rnd_addr", o_ctl_wb_addr, it_addr[e][issued[e]]);
          chk("rnd_wdata", o_ctl_wb_data, it_data[e][issued[e]]);
          chk("rnd_sel", o_ctl_wb_sel, it_sel[e][issued[e]]);
          chk("rnd_we", o_ctl_wb_we, it_we[e][issued[e]]);
          last_due = (last_due > cyc_no) ? last_due : cyc_no;
          rq.push_back('{port: e, aux: it_aux[e][issued[e]], data: {$urandom, $urandom},
                         due: cyc_no + int'($urandom_range(1, 6))});
          issued[e]++;
          turn_cnt++;
          model_out++;
        end
      end
      if (ctl_ack) begin
        exp_vec = '0;
        exp_vec[rq[0].port] = 1'b1;
        chk("rnd_ack", o_wb_ack, exp_vec);
        chk("rnd_rx_aux", o_aux, rq[0].aux);
        chk("rnd_rdata", o_wb_data, rq[0].data);
        acked[rq[0].port]++;
        void'(rq.pop_front());
        model_out--;
      end else begin
        chk("rnd_no_ack", o_wb_ack, 0);
      end
      cyc_no++;
      all_done = 1'b1;
      for (int p = 0; p < NP; p++) if (acked[p] < n_items[p]) all_done = 1'b0;
    end
    chk("rnd_complete", all_done, 1);
    chk("rnd_queue_empty", rq.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
